// File: rtl/axi_regbank_m.sv
// AXI3 slave register bank: NREG 32-bit registers behind independent single-outstanding
// write and read burst engines. Register 0's low LED_W bits drive o_led.
//
// Ports:
//   i_clk0, i_rst          sole rising-edge clock, synchronous active-high reset
//   i_AW*/o_AWREADY        write-address channel (ID, ADDR, LEN, SIZE, BURST, VALID)
//   i_W*/o_WREADY          write-data channel (DATA, STRB, LAST, VALID)
//   o_B*/i_BREADY          write-response channel (ID, RESP, VALID)
//   i_AR*/o_ARREADY        read-address channel (ID, ADDR, LEN, SIZE, BURST, VALID)
//   o_R*/i_RREADY          read-data channel (ID, DATA, RESP, LAST, VALID)
//   o_led                  register 0 bits [LED_W-1:0]
module axi_regbank_m #(
  parameter int unsigned NREG  = 4,
  parameter int unsigned ID_W  = 12,
  parameter int unsigned LED_W = 8
) (
  input  logic            i_clk0,
  input  logic            i_rst,
  input  logic [ID_W-1:0] i_AWID,
  input  logic [31:0]     i_AWADDR,
  input  logic [3:0]      i_AWLEN,
  input  logic [2:0]      i_AWSIZE,
  input  logic [1:0]      i_AWBURST,
  input  logic            i_AWVALID,
  output logic            o_AWREADY,
  input  logic [31:0]     i_WDATA,
  input  logic [3:0]      i_WSTRB,
  input  logic            i_WLAST,
  input  logic            i_WVALID,
  output logic            o_WREADY,
  output logic [ID_W-1:0] o_BID,
  output logic [1:0]      o_BRESP,
  output logic            o_BVALID,
  input  logic            i_BREADY,
  input  logic [ID_W-1:0] i_ARID,
  input  logic [31:0]     i_ARADDR,
  input  logic [3:0]      i_ARLEN,
  input  logic [2:0]      i_ARSIZE,
  input  logic [1:0]      i_ARBURST,
  input  logic            i_ARVALID,
  output logic            o_ARREADY,
  output logic [ID_W-1:0] o_RID,
  output logic [31:0]     o_RDATA,
  output logic [1:0]      o_RRESP,
  output logic            o_RLAST,
  output logic            o_RVALID,
  input  logic            i_RREADY,
  output logic [LED_W-1:0] o_led
);

  localparam int unsigned IdxW = $clog2(NREG);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  // Only the low 12 address bits take part in decode and 4 KB wrapping.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_AWADDR[31:12], i_ARADDR[31:12]};

  function automatic logic addr_in_range(input logic [11:0] a);
    addr_in_range = ((a >> (2 + IdxW)) == 12'd0);
  endfunction

  function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size);
    burst_legal = ((burst == BurstFixed) || (burst == BurstIncr)) && (size == 3'd2);
  endfunction

  logic [31:0] regs_q [NREG];
  logic [31:0] regs_d [NREG];

  // Write path state
  w_state_e        w_state_q, w_state_d;
  logic [ID_W-1:0] aw_id_q, aw_id_d;
  logic [11:0]     aw_addr_q, aw_addr_d;
  logic [3:0]      aw_len_q, aw_len_d;
  logic            aw_incr_q, aw_incr_d;
  logic            aw_illegal_q, aw_illegal_d;
  logic [3:0]      w_beat_q, w_beat_d;
  logic            w_err_q, w_err_d;
  logic [IdxW-1:0] w_idx;
  logic            w_last_beat;

  // Read path state
  r_state_e        r_state_q, r_state_d;
  logic [ID_W-1:0] ar_id_q, ar_id_d;
  logic [11:0]     ar_addr_q, ar_addr_d;
  logic [3:0]      ar_len_q, ar_len_d;
  logic            ar_incr_q, ar_incr_d;
  logic            ar_illegal_q, ar_illegal_d;
  logic [3:0]      r_beat_q, r_beat_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            ld_en;
  logic [11:0]     ld_addr;
  logic            ld_legal;
  logic [11:0]     ar_addr_nxt;

  assign w_idx       = aw_addr_q[2 +: IdxW];
  assign w_last_beat = (w_beat_q == aw_len_q);
  assign ar_addr_nxt = ar_incr_q ? (ar_addr_q + 12'd4) : ar_addr_q;

  always_comb begin
    w_state_d    = w_state_q;
    aw_id_d      = aw_id_q;
    aw_addr_d    = aw_addr_q;
    aw_len_d     = aw_len_q;
    aw_incr_d    = aw_incr_q;
    aw_illegal_d = aw_illegal_q;
    w_beat_d     = w_beat_q;
    w_err_d      = w_err_q;
    regs_d       = regs_q;
    case (w_state_q)
      WIdle: begin
        if (i_AWVALID) begin
          aw_id_d      = i_AWID;
          aw_addr_d    = i_AWADDR[11:0];
          aw_len_d     = i_AWLEN;
          aw_incr_d    = (i_AWBURST == BurstIncr);
          aw_illegal_d = !burst_legal(i_AWBURST, i_AWSIZE);
          w_err_d      = !burst_legal(i_AWBURST, i_AWSIZE);
          w_beat_d     = 4'd0;
          w_state_d    = WData;
        end
      end
      WData: begin
        if (i_WVALID) begin
          if (!aw_illegal_q && addr_in_range(aw_addr_q)) begin
            for (int k = 0; k < 4; k++) begin
              if (i_WSTRB[k]) regs_d[w_idx][8*k +: 8] = i_WDATA[8*k +: 8];
            end
          end
          // WLAST never ends the burst; a misplaced one only poisons the response.
          w_err_d   = w_err_q | !addr_in_range(aw_addr_q) | (i_WLAST != w_last_beat);
          aw_addr_d = aw_incr_q ? (aw_addr_q + 12'd4) : aw_addr_q;
          w_beat_d  = w_beat_q + 4'd1;
          if (w_last_beat) w_state_d = WResp;
        end
      end
      WResp: begin
        if (i_BREADY) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d    = r_state_q;
    ar_id_d      = ar_id_q;
    ar_addr_d    = ar_addr_q;
    ar_len_d     = ar_len_q;
    ar_incr_d    = ar_incr_q;
    ar_illegal_d = ar_illegal_q;
    r_beat_d     = r_beat_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    ld_en        = 1'b0;
    ld_addr      = 12'd0;
    ld_legal     = 1'b0;
    case (r_state_q)
      RIdle: begin
        if (i_ARVALID) begin
          ar_id_d      = i_ARID;
          ar_addr_d    = i_ARADDR[11:0];
          ar_len_d     = i_ARLEN;
          ar_incr_d    = (i_ARBURST == BurstIncr);
          ar_illegal_d = !burst_legal(i_ARBURST, i_ARSIZE);
          r_beat_d     = 4'd0;
          ld_en        = 1'b1;
          ld_addr      = i_ARADDR[11:0];
          ld_legal     = burst_legal(i_ARBURST, i_ARSIZE);
          r_state_d    = RData;
        end
      end
      RData: begin
        if (i_RREADY) begin
          if (r_beat_q == ar_len_q) begin
            r_state_d = RIdle;
          end else begin
            ar_addr_d = ar_addr_nxt;
            r_beat_d  = r_beat_q + 4'd1;
            ld_en     = 1'b1;
            ld_addr   = ar_addr_nxt;
            ld_legal  = !ar_illegal_q;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
    // Loads sample regs_q, so a write landing on the same edge is not seen.
    if (ld_en) begin
      if (ld_legal && addr_in_range(ld_addr)) begin
        rdata_d = regs_q[ld_addr[2 +: IdxW]];
        rresp_d = RespOkay;
      end else begin
        rdata_d = 32'd0;
        rresp_d = RespSlverr;
      end
    end
  end

  always_ff @(posedge i_clk0) begin
    if (i_rst) begin
      w_state_q    <= WIdle;
      aw_id_q      <= '0;
      aw_addr_q    <= '0;
      aw_len_q     <= '0;
      aw_incr_q    <= 1'b0;
      aw_illegal_q <= 1'b0;
      w_beat_q     <= '0;
      w_err_q      <= 1'b0;
      r_state_q    <= RIdle;
      ar_id_q      <= '0;
      ar_addr_q    <= '0;
      ar_len_q     <= '0;
      ar_incr_q    <= 1'b0;
      ar_illegal_q <= 1'b0;
      r_beat_q     <= '0;
      rdata_q      <= '0;
      rresp_q      <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      w_state_q    <= w_state_d;
      aw_id_q      <= aw_id_d;
      aw_addr_q    <= aw_addr_d;
      aw_len_q     <= aw_len_d;
      aw_incr_q    <= aw_incr_d;
      aw_illegal_q <= aw_illegal_d;
      w_beat_q     <= w_beat_d;
      w_err_q      <= w_err_d;
      r_state_q    <= r_state_d;
      ar_id_q      <= ar_id_d;
      ar_addr_q    <= ar_addr_d;
      ar_len_q     <= ar_len_d;
      ar_incr_q    <= ar_incr_d;
      ar_illegal_q <= ar_illegal_d;
      r_beat_q     <= r_beat_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign o_AWREADY = (w_state_q == WIdle);
  assign o_WREADY  = (w_state_q == WData);
  assign o_BVALID  = (w_state_q == WResp);
  assign o_BRESP   = (o_BVALID && w_err_q) ? RespSlverr : RespOkay;
  assign o_BID     = aw_id_q;

  assign o_ARREADY = (r_state_q == RIdle);
  assign o_RVALID  = (r_state_q == RData);
  assign o_RLAST   = o_RVALID && (r_beat_q == ar_len_q);
  assign o_RDATA   = rdata_q;
  assign o_RRESP   = rresp_q;
  assign o_RID     = ar_id_q;

  assign o_led = regs_q[0][LED_W-1:0];

endmodule

// File: tb/tb_axi_regbank_m.sv
module tb_axi_regbank_m;
  localparam int NREG  = 4;
  localparam int ID_W  = 12;
  localparam int LED_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_rst = 1'b0;
  logic [ID_W-1:0] i_AWID = '0;
  logic [31:0]     i_AWADDR = '0;
  logic [3:0]      i_AWLEN = '0;
  logic [2:0]      i_AWSIZE = '0;
  logic [1:0]      i_AWBURST = '0;
  logic            i_AWVALID = 1'b0;
  logic            o_AWREADY;
  logic [31:0]     i_WDATA = '0;
  logic [3:0]      i_WSTRB = '0;
  logic            i_WLAST = 1'b0;
  logic            i_WVALID = 1'b0;
  logic            o_WREADY;
  logic [ID_W-1:0] o_BID;
  logic [1:0]      o_BRESP;
  logic            o_BVALID;
  logic            i_BREADY = 1'b0;
  logic [ID_W-1:0] i_ARID = '0;
  logic [31:0]     i_ARADDR = '0;
  logic [3:0]      i_ARLEN = '0;
  logic [2:0]      i_ARSIZE = '0;
  logic [1:0]      i_ARBURST = '0;
  logic            i_ARVALID = 1'b0;
  logic            o_ARREADY;
  logic [ID_W-1:0] o_RID;
  logic [31:0]     o_RDATA;
  logic [1:0]      o_RRESP;
  logic            o_RLAST;
  logic            o_RVALID;
  logic            i_RREADY = 1'b0;
  logic [LED_W-1:0] o_led;

  axi_regbank_m #(.NREG(NREG), .ID_W(ID_W), .LED_W(LED_W)) dut (
    .i_clk0(clk), .i_rst(i_rst),
    .i_AWID(i_AWID), .i_AWADDR(i_AWADDR), .i_AWLEN(i_AWLEN), .i_AWSIZE(i_AWSIZE),
    .i_AWBURST(i_AWBURST), .i_AWVALID(i_AWVALID), .o_AWREADY(o_AWREADY),
    .i_WDATA(i_WDATA), .i_WSTRB(i_WSTRB), .i_WLAST(i_WLAST), .i_WVALID(i_WVALID),
    .o_WREADY(o_WREADY),
    .o_BID(o_BID), .o_BRESP(o_BRESP), .o_BVALID(o_BVALID), .i_BREADY(i_BREADY),
    .i_ARID(i_ARID), .i_ARADDR(i_ARADDR), .i_ARLEN(i_ARLEN), .i_ARSIZE(i_ARSIZE),
    .i_ARBURST(i_ARBURST), .i_ARVALID(i_ARVALID), .o_ARREADY(o_ARREADY),
    .o_RID(o_RID), .o_RDATA(o_RDATA), .o_RRESP(o_RRESP), .o_RLAST(o_RLAST),
    .o_RVALID(o_RVALID), .i_RREADY(i_RREADY),
    .o_led(o_led)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: register contents plus per-burst stimulus/expectation arrays.
  logic [31:0] m_regs [NREG];
  logic [31:0] w_data [16];
  logic [3:0]  w_strb [16];
  logic [15:0] w_last;
  logic [31:0] e_data [16];
  logic [1:0]  e_resp [16];
  logic [31:0] r_data_got [16];
  logic [1:0]  r_resp_got [16];
  logic [15:0] r_last_got;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 32'd0;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             output logic [1:0] exp_resp);
    int a;
    bit legal, err;
    legal = ((burst == 2'b00) || (burst == 2'b01)) && (size == 3'd2);
    err = !legal;
    a = int'(addr % 4096);
    for (int b = 0; b <= int'(len); b++) begin
      if (a < NREG * 4) begin
        if (legal)
          for (int k = 0; k < 4; k++)
            if (w_strb[b][k]) m_regs[a / 4][8*k +: 8] = w_data[b][8*k +: 8];
      end else begin
        err = 1'b1;
      end
      if (w_last[b] != (b == int'(len))) err = 1'b1;
      if (burst == 2'b01) a = (a + 4) % 4096;
    end
    exp_resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic model_read(input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    int a;
    bit legal;
    legal = ((burst == 2'b00) || (burst == 2'b01)) && (size == 3'd2);
    a = int'(addr % 4096);
    for (int b = 0; b <= int'(len); b++) begin
      if (legal && a < NREG * 4) begin
        e_data[b] = m_regs[a / 4];
        e_resp[b] = 2'b00;
      end else begin
        e_data[b] = 32'd0;
        e_resp[b] = 2'b10;
      end
      if (burst == 2'b01) a = (a + 4) % 4096;
    end
  endtask

  task automatic axi_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst,
                           output logic [1:0] resp, output logic [ID_W-1:0] bid);
    int n;
    i_AWID = id; i_AWADDR = addr; i_AWLEN = len; i_AWSIZE = size; i_AWBURST = burst;
    i_AWVALID = 1'b1;
    n = 0;
    while (o_AWREADY !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin vectors++; miscompares++; $display("FAIL aw_timeout"); end
    @(posedge clk); #1;
    i_AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      i_WDATA = w_data[b]; i_WSTRB = w_strb[b]; i_WLAST = w_last[b]; i_WVALID = 1'b1;
      n = 0;
      while (o_WREADY !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin vectors++; miscompares++; $display("FAIL w_timeout beat %0d", b); end
      @(posedge clk); #1;
    end
    i_WVALID = 1'b0; i_WLAST = 1'b0;
    i_BREADY = 1'b1;
    n = 0;
    while (o_BVALID !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin vectors++; miscompares++; $display("FAIL b_timeout"); end
    resp = o_BRESP; bid = o_BID;
    @(posedge clk); #1;
    i_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, output logic [ID_W-1:0] rid);
    int n;
    i_ARID = id; i_ARADDR = addr; i_ARLEN = len; i_ARSIZE = size; i_ARBURST = burst;
    i_ARVALID = 1'b1;
    n = 0;
    while (o_ARREADY !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin vectors++; miscompares++; $display("FAIL ar_timeout"); end
    @(posedge clk); #1;
    i_ARVALID = 1'b0;
    i_RREADY = 1'b1;
    rid = '0;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (o_RVALID !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin vectors++; miscompares++; $display("FAIL r_timeout beat %0d", b); end
      r_data_got[b] = o_RDATA; r_resp_got[b] = o_RRESP; r_last_got[b] = o_RLAST; rid = o_RID;
      @(posedge clk); #1;
    end
    i_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    vectors++;
    if ({o_AWREADY, o_ARREADY, o_WREADY, o_BVALID, o_RVALID, o_RLAST} !== 6'b110000) begin
      miscompares++;
      $display("FAIL reset_handshake: got %b want 110000",
               {o_AWREADY, o_ARREADY, o_WREADY, o_BVALID, o_RVALID, o_RLAST});
    end
    vectors++;
    if (o_RDATA !== 32'd0 || o_BRESP !== 2'b00 || o_RRESP !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_data: rdata %h bresp %b rresp %b want 0", o_RDATA, o_BRESP, o_RRESP);
    end
    vectors++;
    if (o_led !== '0) begin miscompares++; $display("FAIL reset_led: got %h want 0", o_led); end
    i_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    logic [1:0] resp, er;
    logic [ID_W-1:0] bid, rid;
    w_data[0] = 32'hA5A5_00FF; w_strb[0] = 4'hF; w_last = 16'h0001;
    model_write(32'h0, 4'd0, 3'd2, 2'b01, er);
    axi_write(12'h5A3, 32'h0, 4'd0, 3'd2, 2'b01, resp, bid);
    vectors++;
    if (resp !== er || resp !== 2'b00) begin
      miscompares++; $display("FAIL single_bresp: got %b want 00", resp);
    end
    vectors++;
    if (bid !== 12'h5A3) begin miscompares++; $display("FAIL single_bid: got %h want 5a3", bid); end
    vectors++;
    if (o_led !== 8'hFF) begin miscompares++; $display("FAIL single_led: got %h want ff", o_led); end
    model_read(32'h0, 4'd0, 3'd2, 2'b01);
    axi_read(12'h0C1, 32'h0, 4'd0, 3'd2, 2'b01, rid);
    vectors++;
    if (r_data_got[0] !== 32'hA5A5_00FF || r_last_got[0] !== 1'b1 || rid !== 12'h0C1) begin
      miscompares++;
      $display("FAIL single_read: data %h last %b rid %h want a5a500ff 1 0c1",
               r_data_got[0], r_last_got[0], rid);
    end
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp, er;
    logic [ID_W-1:0] bid, rid;
    for (int b = 0; b < 4; b++) begin w_data[b] = 32'(b + 1); w_strb[b] = 4'hF; end
    w_data[2] = 32'hDEAD_0003; w_strb[2] = 4'h3; w_last = 16'h0008;
    model_write(32'h0, 4'd3, 3'd2, 2'b01, er);
    axi_write(12'h111, 32'h0, 4'd3, 3'd2, 2'b01, resp, bid);
    vectors++;
    if (resp !== er) begin miscompares++; $display("FAIL incr_bresp: got %b want %b", resp, er); end
    model_read(32'h0, 4'd3, 3'd2, 2'b01);
    axi_read(12'h222, 32'h0, 4'd3, 3'd2, 2'b01, rid);
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (r_data_got[b] !== e_data[b] || r_resp_got[b] !== 2'b00 || r_last_got[b] !== (b == 3)) begin
        miscompares++;
        $display("FAIL incr_read beat %0d: data %h resp %b last %b want %h 00 %b",
                 b, r_data_got[b], r_resp_got[b], r_last_got[b], e_data[b], (b == 3));
      end
    end
    vectors++;
    if (e_data[2] !== 32'h0000_0003 || rid !== 12'h222) begin
      miscompares++; $display("FAIL incr_strobe: reg2 %h rid %h want 00000003 222", e_data[2], rid);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp, er;
    logic [ID_W-1:0] bid, rid;
    w_data[0] = 32'hFFFF_FFFF; w_data[1] = 32'h1234_5678;
    w_strb[0] = 4'hF; w_strb[1] = 4'hF; w_last = 16'h0002;
    model_write(32'h40, 4'd1, 3'd2, 2'b01, er);
    axi_write(12'h333, 32'h40, 4'd1, 3'd2, 2'b01, resp, bid);
    vectors++;
    if (resp !== 2'b10 || er !== 2'b10) begin
      miscompares++; $display("FAIL oor_bresp: got %b want 10", resp);
    end
    model_read(32'h0, 4'd3, 3'd2, 2'b01);
    axi_read(12'h334, 32'h0, 4'd3, 3'd2, 2'b01, rid);
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (r_data_got[b] !== e_data[b]) begin
        miscompares++; $display("FAIL oor_regs %0d: got %h want %h", b, r_data_got[b], e_data[b]);
      end
    end
    axi_read(12'h335, 32'h40, 4'd0, 3'd2, 2'b01, rid);
    vectors++;
    if (r_data_got[0] !== 32'd0 || r_resp_got[0] !== 2'b10) begin
      miscompares++;
      $display("FAIL oor_read: data %h resp %b want 0 10", r_data_got[0], r_resp_got[0]);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] resp, er;
    logic [ID_W-1:0] bid, rid;
    for (int b = 0; b < 4; b++) begin w_data[b] = 32'hCAFE_0000 + 32'(b); w_strb[b] = 4'hF; end
    w_last = 16'h0008;
    model_write(32'h0, 4'd3, 3'd2, 2'b10, er);
    axi_write(12'h444, 32'h0, 4'd3, 3'd2, 2'b10, resp, bid);
    vectors++;
    if (resp !== 2'b10) begin miscompares++; $display("FAIL wrap_bresp: got %b want 10", resp); end
    w_last = 16'h0002;
    model_write(32'h4, 4'd1, 3'd1, 2'b01, er);
    axi_write(12'h445, 32'h4, 4'd1, 3'd1, 2'b01, resp, bid);
    vectors++;
    if (resp !== 2'b10) begin miscompares++; $display("FAIL size_bresp: got %b want 10", resp); end
    // Misplaced WLAST on a legal burst: data lands, response is an error.
    w_data[0] = 32'h0BAD_1A57; w_data[1] = 32'h600D_F00D; w_last = 16'h0001;
    model_write(32'h8, 4'd1, 3'd2, 2'b01, er);
    axi_write(12'h446, 32'h8, 4'd1, 3'd2, 2'b01, resp, bid);
    vectors++;
    if (resp !== 2'b10 || er !== 2'b10) begin
      miscompares++; $display("FAIL wlast_bresp: got %b want 10", resp);
    end
    model_read(32'h0, 4'd3, 3'd2, 2'b01);
    axi_read(12'h447, 32'h0, 4'd3, 3'd2, 2'b01, rid);
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (r_data_got[b] !== e_data[b]) begin
        miscompares++; $display("FAIL illegal_regs %0d: got %h want %h", b, r_data_got[b], e_data[b]);
      end
    end
    axi_read(12'h448, 32'h0, 4'd0, 3'd2, 2'b10, rid);
    vectors++;
    if (r_data_got[0] !== 32'd0 || r_resp_got[0] !== 2'b10) begin
      miscompares++;
      $display("FAIL wrap_read: data %h resp %b want 0 10", r_data_got[0], r_resp_got[0]);
    end
  endtask

  task automatic test_concurrent();
    logic [1:0] resp, er;
    logic [ID_W-1:0] bid, rid;
    logic [31:0] old_val;
    old_val = m_regs[1];
    w_data[0] = ~old_val; w_strb[0] = 4'hF; w_last = 16'h0001;
    model_read(32'h4, 4'd0, 3'd2, 2'b01);
    model_write(32'h4, 4'd0, 3'd2, 2'b01, er);
    fork
      axi_write(12'h555, 32'h4, 4'd0, 3'd2, 2'b01, resp, bid);
      begin
        @(posedge clk); #1;
        axi_read(12'h556, 32'h4, 4'd0, 3'd2, 2'b01, rid);
      end
    join
    vectors++;
    if (r_data_got[0] !== e_data[0]) begin
      miscompares++; $display("FAIL collide_read: got %h want %h", r_data_got[0], e_data[0]);
    end
    model_read(32'h4, 4'd0, 3'd2, 2'b01);
    axi_read(12'h557, 32'h4, 4'd0, 3'd2, 2'b01, rid);
    vectors++;
    if (r_data_got[0] !== e_data[0]) begin
      miscompares++; $display("FAIL collide_after: got %h want %h", r_data_got[0], e_data[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] er;
    w_data[0] = 32'h0000_5A5A; w_strb[0] = 4'hF; w_last = 16'h0001;
    model_write(32'hC, 4'd0, 3'd2, 2'b01, er);
    i_AWID = 12'h777; i_AWADDR = 32'hC; i_AWLEN = 4'd0; i_AWSIZE = 3'd2; i_AWBURST = 2'b01;
    i_AWVALID = 1'b1;
    @(posedge clk); #1;
    i_AWVALID = 1'b0;
    i_WDATA = w_data[0]; i_WSTRB = 4'hF; i_WLAST = 1'b1; i_WVALID = 1'b1;
    @(posedge clk); #1;
    i_WVALID = 1'b0; i_WLAST = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (o_BVALID !== 1'b1 || o_BRESP !== er || o_BID !== 12'h777 || o_AWREADY !== 1'b0) begin
        miscompares++;
        $display("FAIL b_stall cyc %0d: bvalid %b bresp %b bid %h awready %b want 1 %b 777 0",
                 c, o_BVALID, o_BRESP, o_BID, o_AWREADY, er);
      end
      @(posedge clk); #1;
    end
    i_BREADY = 1'b1;
    @(posedge clk); #1;
    i_BREADY = 1'b0;
    vectors++;
    if (o_BVALID !== 1'b0 || o_AWREADY !== 1'b1) begin
      miscompares++; $display("FAIL b_release: bvalid %b awready %b want 0 1", o_BVALID, o_AWREADY);
    end
    model_read(32'h8, 4'd1, 3'd2, 2'b01);
    i_ARID = 12'h778; i_ARADDR = 32'h8; i_ARLEN = 4'd1; i_ARSIZE = 3'd2; i_ARBURST = 2'b01;
    i_ARVALID = 1'b1;
    @(posedge clk); #1;
    i_ARVALID = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (o_RVALID !== 1'b1 || o_RDATA !== e_data[0] || o_RID !== 12'h778 ||
          o_RLAST !== 1'b0 || o_ARREADY !== 1'b0) begin
        miscompares++;
        $display("FAIL r_stall cyc %0d: rvalid %b rdata %h rid %h rlast %b arready %b want 1 %h 778 0 0",
                 c, o_RVALID, o_RDATA, o_RID, o_RLAST, o_ARREADY, e_data[0]);
      end
      @(posedge clk); #1;
    end
    i_RREADY = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (o_RVALID !== 1'b1 || o_RDATA !== e_data[1] || o_RLAST !== 1'b1) begin
      miscompares++;
      $display("FAIL r_beat2: rvalid %b rdata %h rlast %b want 1 %h 1", o_RVALID, o_RDATA, o_RLAST,
               e_data[1]);
    end
    @(posedge clk); #1;
    i_RREADY = 1'b0;
    vectors++;
    if (o_RVALID !== 1'b0 || o_ARREADY !== 1'b1) begin
      miscompares++; $display("FAIL r_release: rvalid %b arready %b want 0 1", o_RVALID, o_ARREADY);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, er, burst;
    logic [ID_W-1:0] id, bid, rid;
    logic [31:0] addr;
    logic [3:0] len;
    logic [2:0] size;
    int sel;
    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom_range(0, 7));
      if (sel < 5) addr = 32'($urandom_range(0, NREG * 4 - 1));
      else if (sel == 5) addr = 32'($urandom_range(0, 255));
      else if (sel == 6) addr = 32'hFF0 + 32'($urandom_range(0, 3) * 4);
      else addr = $urandom;
      sel = int'($urandom_range(0, 9));
      burst = (sel < 7) ? 2'b01 : ((sel < 9) ? 2'b00 : 2'b10);
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      len = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      id = 12'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 16; b++) begin
          w_data[b] = $urandom; w_strb[b] = 4'($urandom_range(0, 15));
        end
        w_last = 16'd1 << len;
        if ($urandom_range(0, 7) == 0) w_last = w_last ^ (16'd1 << $urandom_range(0, 15));
        model_write(addr, len, size, burst, er);
        axi_write(id, addr, len, size, burst, resp, bid);
        vectors++;
        if (resp !== er || bid !== id) begin
          miscompares++;
          $display("FAIL rnd_write %0d: bresp %b bid %h want %b %h", t, resp, bid, er, id);
        end
        vectors++;
        if (o_led !== m_regs[0][LED_W-1:0]) begin
          miscompares++; $display("FAIL rnd_led %0d: got %h want %h", t, o_led, m_regs[0][LED_W-1:0]);
        end
      end else begin
        model_read(addr, len, size, burst);
        axi_read(id, addr, len, size, burst, rid);
        vectors++;
        if (rid !== id) begin miscompares++; $display("FAIL rnd_rid %0d: got %h want %h", t, rid, id); end
        for (int b = 0; b <= int'(len); b++) begin
          vectors++;
          if (r_data_got[b] !== e_data[b] || r_resp_got[b] !== e_resp[b] ||
              r_last_got[b] !== (b == int'(len))) begin
            miscompares++;
            $display("FAIL rnd_read %0d beat %0d: data %h resp %b last %b want %h %b %b", t, b,
                     r_data_got[b], r_resp_got[b], r_last_got[b], e_data[b], e_resp[b],
                     (b == int'(len)));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [ID_W-1:0] rid;
    i_AWID = 12'h999; i_AWADDR = 32'h0; i_AWLEN = 4'd3; i_AWSIZE = 3'd2; i_AWBURST = 2'b01;
    i_AWVALID = 1'b1;
    @(posedge clk); #1;
    i_AWVALID = 1'b0;
    i_WDATA = 32'h1111_1111; i_WSTRB = 4'hF; i_WLAST = 1'b0; i_WVALID = 1'b1;
    @(posedge clk); #1;
    i_WDATA = 32'h2222_2222; i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    model_reset();
    vectors++;
    if ({o_AWREADY, o_ARREADY, o_WREADY, o_BVALID, o_RVALID, o_RLAST} !== 6'b110000 ||
        o_RDATA !== 32'd0 || o_BRESP !== 2'b00 || o_RRESP !== 2'b00 || o_led !== '0) begin
      miscompares++;
      $display("FAIL midrst_outputs: flags %b rdata %h bresp %b rresp %b led %h want 110000 0 0 0 0",
               {o_AWREADY, o_ARREADY, o_WREADY, o_BVALID, o_RVALID, o_RLAST}, o_RDATA, o_BRESP,
               o_RRESP, o_led);
    end
    for (int c = 0; c < 2; c++) begin
      i_WDATA = 32'h3333_3333 + 32'(c) * 32'h1111_1111; i_WLAST = (c == 1);
      @(posedge clk); #1;
      vectors++;
      if (o_WREADY !== 1'b0 || o_BVALID !== 1'b0) begin
        miscompares++; $display("FAIL midrst_idle %0d: wready %b bvalid %b want 0 0", c, o_WREADY,
                                o_BVALID);
      end
    end
    i_WVALID = 1'b0; i_WLAST = 1'b0;
    model_read(32'h0, 4'd3, 3'd2, 2'b01);
    axi_read(12'h99A, 32'h0, 4'd3, 3'd2, 2'b01, rid);
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (r_data_got[b] !== e_data[b] || r_data_got[b] !== 32'd0) begin
        miscompares++; $display("FAIL midrst_regs %0d: got %h want 0", b, r_data_got[b]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr_burst();
    test_out_of_range();
    test_illegal();
    test_concurrent();
    test_backpressure();
    test_random();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
